// File: rtl/pe_pkg.sv
// Shared widths and signed data types for the systolic processing element.
package pe_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SUM_W  = 16;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply-add: y = a*b + c, wrapping modulo 2^SUM_W.
module pe_mac
    import pe_pkg::*;
(
    input  data_t a,
    input  data_t b,
    input  sum_t  c,
    output sum_t  y
);

    sum_t prod;

    // Both operands are sign-extended to the sum width, so the full 8x8 product fits exactly
    always_comb begin
        prod = sum_t'(a) * sum_t'(b);
        y    = prod + c;
    end

endmodule

// File: rtl/pe.sv
// Weight-stationary systolic PE: holds one weight, forwards data/active east,
// forwards weights and partial sums south. All outputs are registered.
module pe
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic [DATA_W-1:0] datain,
    input  logic [DATA_W-1:0] win,
    input  logic [SUM_W-1:0]  sumin,
    input  logic              wwrite,
    output logic [SUM_W-1:0]  maccout,
    output logic [DATA_W-1:0] dataout,
    output logic [DATA_W-1:0] wout,
    output logic              wwriteout,
    output logic              activeout
);

    data_t weight_q,  weight_d;
    sum_t  macc_q,    macc_d;
    data_t data_q,    data_d;
    logic  wwrite_q,  wwrite_d;
    logic  active_q,  active_d;
    sum_t  mac_y;

    // MAC always uses the weight held before this edge, even when a new weight is loading
    pe_mac u_mac (
        .a (data_t'(datain)),
        .b (weight_q),
        .c (sum_t'(sumin)),
        .y (mac_y)
    );

    // Next-state: weight loads on wwrite, partial sum updates only when active
    always_comb begin
        weight_d = wwrite ? data_t'(win) : weight_q;
        macc_d   = active ? mac_y : macc_q;
        data_d   = data_t'(datain);
        wwrite_d = wwrite;
        active_d = active;
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= '0;
            macc_q   <= '0;
            data_q   <= '0;
            wwrite_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            weight_q <= weight_d;
            macc_q   <= macc_d;
            data_q   <= data_d;
            wwrite_q <= wwrite_d;
            active_q <= active_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        maccout   = macc_q;
        dataout   = data_q;
        wout      = weight_q;
        wwriteout = wwrite_q;
        activeout = active_q;
    end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed cases plus randomized traffic against a
// behavioural model of the PE written with plain signed integer arithmetic.
module tb_pe;
    import pe_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              active;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] win;
    logic [SUM_W-1:0]  sumin;
    logic              wwrite;
    logic [SUM_W-1:0]  maccout;
    logic [DATA_W-1:0] dataout;
    logic [DATA_W-1:0] wout;
    logic              wwriteout;
    logic              activeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_weight = 0;   // signed weight value
    int m_macc   = 0;   // partial sum, kept in 0..65535
    int m_data   = 0;   // 0..255
    int m_wwo    = 0;
    int m_act    = 0;

    pe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .datain    (datain),
        .win       (win),
        .sumin     (sumin),
        .wwrite    (wwrite),
        .maccout   (maccout),
        .dataout   (dataout),
        .wout      (wout),
        .wwriteout (wwriteout),
        .activeout (activeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int to_signed8(input int v);
        return (v & 255) >= 128 ? (v & 255) - 256 : (v & 255);
    endfunction

    function automatic int to_signed16(input int v);
        return (v & 65535) >= 32768 ? (v & 65535) - 65536 : (v & 65535);
    endfunction

    task automatic model_clear();
        m_weight = 0; m_macc = 0; m_data = 0; m_wwo = 0; m_act = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".macc"},   32'(maccout),   32'(m_macc));
        check({tag, ".data"},   32'(dataout),   32'(m_data));
        check({tag, ".wout"},   32'(wout),      32'(m_weight & 255));
        check({tag, ".wwo"},    32'(wwriteout), 32'(m_wwo));
        check({tag, ".act"},    32'(activeout), 32'(m_act));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check 1 ns later
    task automatic cycle(input string tag, input logic act, input logic [7:0] dat,
                         input logic [7:0] w, input logic [15:0] s, input logic ww);
        int d_i, s_i, old_w;
        active = act; datain = dat; win = w; sumin = s; wwrite = ww;
        @(posedge clk);
        if (rst_n) begin
            d_i   = to_signed8(int'(dat));
            s_i   = to_signed16(int'(s));
            old_w = m_weight;
            if (act) m_macc = (s_i + d_i * old_w) & 65535;
            if (ww)  m_weight = to_signed8(int'(w));
            m_data = int'(dat);
            m_wwo  = int'(ww);
            m_act  = int'(act);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] prev_win;
        rst_n = 1'b0; active = 1'b0; datain = '0; win = '0; sumin = '0; wwrite = 1'b0;

        // 1: reset held while controls toggle
        for (int unsigned i = 0; i < 4; i++)
            cycle("rst", 1'(i), 8'h5A, 8'h33, 16'h1234, 1'(~i));
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0);
        check("post_rst.wout0", 32'(wout), 32'h0);

        // 2: weight ramp through the shift path, then freeze
        prev_win = 8'h00;
        for (int unsigned i = 1; i <= 6; i++) begin
            cycle("ramp", 1'b0, 8'h00, 8'(4 * i), 16'h0, 1'b1);
            check("ramp.wout_prev", 32'(wout), 32'(4 * i));
            check("ramp.wwo", 32'(wwriteout), 32'h1);
            prev_win = 8'(4 * i);
        end
        for (int unsigned i = 1; i <= 4; i++) begin
            cycle("freeze", 1'b0, 8'h00, 8'(prev_win + 2 * i), 16'h0, 1'b0);
            check("freeze.wout", 32'(wout), 32'(prev_win));
            check("freeze.wwo", 32'(wwriteout), 32'h0);
        end

        // 3: basic MAC
        cycle("ld3", 1'b0, 8'h00, 8'h03, 16'h0, 1'b1);
        cycle("mac3", 1'b1, 8'h05, 8'h00, 16'h0010, 1'b0);
        check("mac3.const", 32'(maccout), 32'h001F);
        check("mac3.dout", 32'(dataout), 32'h05);
        check("mac3.aout", 32'(activeout), 32'h1);

        // 4: signed extremes and wrap
        cycle("ld4a", 1'b0, 8'h00, 8'h80, 16'h0, 1'b1);
        cycle("mac4a", 1'b1, 8'h80, 8'h00, 16'h7FFF, 1'b0);
        check("mac4a.wrap", 32'(maccout), 32'hBFFF);
        cycle("ld4b", 1'b0, 8'h00, 8'hFF, 16'h0, 1'b1);
        cycle("mac4b", 1'b1, 8'h02, 8'h00, 16'h0000, 1'b0);
        check("mac4b.neg", 32'(maccout), 32'hFFFE);

        // 5: hold with active low (including undriven data), then load/MAC overlap
        cycle("hold1", 1'b0, 8'h11, 8'h00, 16'h4444, 1'b0);
        check("hold1.const", 32'(maccout), 32'hFFFE);
        cycle("holdx", 1'b0, 'x, 8'h00, 'x, 1'b0);
        check("holdx.const", 32'(maccout), 32'hFFFE);
        cycle("ovl1", 1'b1, 8'h03, 8'h02, 16'h0000, 1'b1);
        check("ovl1.oldw", 32'(maccout), 32'hFFFD);
        cycle("ovl2", 1'b1, 8'h03, 8'h00, 16'h0000, 1'b0);
        check("ovl2.neww", 32'(maccout), 32'h0006);

        // Randomized traffic with occasional mid-cycle asynchronous reset
        for (int unsigned i = 0; i < 400; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  16'($urandom), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 49) == 0) begin
                // 6: clear between edges, must be visible before the next posedge
                #2 rst_n = 1'b0;
                #1;
                model_clear();
                check_all("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // 6 (directed): async reset with nonzero state
        cycle("pre_ar", 1'b1, 8'h7F, 8'h7F, 16'h1111, 1'b1);
        cycle("pre_ar2", 1'b1, 8'h7F, 8'h00, 16'h1111, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("ar.macc", 32'(maccout), 32'h0);
        check("ar.wout", 32'(wout), 32'h0);
        check("ar.dout", 32'(dataout), 32'h0);
        check("ar.wwo", 32'(wwriteout), 32'h0);
        check("ar.aout", 32'(activeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("after_ar", 1'b1, 8'h02, 8'h00, 16'h0005, 1'b0);
        check("after_ar.const", 32'(maccout), 32'h0005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
